// File: rtl/ioctl_download_streamer.sv
// ioctl download transmitter: buffers 32-bit words from the bridge in a small
// FIFO and replays each word as two 16-bit ioctl writes with a byte address,
// holding ioctl_download (and cart_download for ROM images) for the transfer.
module ioctl_download_streamer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int WAIT_LATENCY = 2,
    parameter int TAIL_CYCLES  = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_start,
    input  logic        dl_is_cart,
    input  logic [24:0] dl_length,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        dl_busy,
    output logic        dl_done,
    output logic        ioctl_download,
    output logic        cart_download,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_dout,
    input  logic        ioctl_wait
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(WAIT_LATENCY + 2);
    localparam int TW = $clog2(TAIL_CYCLES + 2);
    localparam logic [HW-1:0] HOLD_LAST = HW'(WAIT_LATENCY);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYCLES);

    typedef enum logic [2:0] {
        IDLE, FETCH, WR_LO, HOLD_LO, WR_HI, HOLD_HI, TAIL, DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_word;
    logic [24:0]   r_addr;
    logic [24:0]   r_remaining;
    logic          r_is_cart;
    logic [24:0]   r_ioctl_addr;
    logic [15:0]   r_ioctl_dout;
    logic [HW-1:0] r_hold_cnt;
    logic [TW-1:0] r_tail_cnt;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_active;
    logic          w_hold_done;
    logic          w_load_lo;
    logic          w_load_hi;
    logic          w_advance;
    logic [24:0]   w_rem_after;
    logic [31:0]   w_head;
    logic [15:0]   w_lo_dout;
    logic [15:0]   w_hi_dout;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_active = (r_state != IDLE) && (r_state != DONE);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    // Remaining bytes after the halfword being acknowledged; a lone odd byte
    // still consumes a whole halfword.
    assign w_rem_after = (r_remaining >= 25'd2) ? (r_remaining - 25'd2) : 25'd0;
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    // Bytes past the end of the image are padded with zero.
    assign w_lo_dout = {(r_remaining == 25'd1) ? 8'h00 : w_head[23:16], w_head[31:24]};
    assign w_hi_dout = {(w_rem_after == 25'd1) ? 8'h00 : r_word[7:0], r_word[15:8]};

    assign in_ready       = w_active && !w_full;
    assign dl_busy        = w_active;
    assign dl_done        = (r_state == DONE);
    assign ioctl_download = w_active;
    assign cart_download  = w_active && r_is_cart;
    assign ioctl_wr       = (r_state == WR_LO) || (r_state == WR_HI);
    assign ioctl_addr     = r_ioctl_addr;
    assign ioctl_dout     = r_ioctl_dout;

    // Next-state decode; fetch also waits for the receiver so no write issues into a busy sink.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load_lo    = 1'b0;
        w_load_hi    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dl_start) begin
                    w_state_next = (dl_length == 25'd0) ? TAIL : FETCH;
                end
            end
            FETCH: begin
                if (!w_empty && !ioctl_wait) begin
                    w_pop        = 1'b1;
                    w_load_lo    = 1'b1;
                    w_state_next = WR_LO;
                end
            end
            WR_LO: w_state_next = HOLD_LO;
            HOLD_LO: begin
                if (w_hold_done && !ioctl_wait) begin
                    w_advance = 1'b1;
                    if (w_rem_after == 25'd0) begin
                        w_state_next = TAIL;
                    end else begin
                        w_load_hi    = 1'b1;
                        w_state_next = WR_HI;
                    end
                end
            end
            WR_HI: w_state_next = HOLD_HI;
            HOLD_HI: begin
                if (w_hold_done && !ioctl_wait) begin
                    w_advance    = 1'b1;
                    w_state_next = (w_rem_after == 25'd0) ? TAIL : FETCH;
                end
            end
            TAIL: begin
                if (r_tail_cnt == TAIL_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // State, FIFO pointers, transfer counters and the registered write bus.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_is_cart    <= 1'b0;
            r_ioctl_addr <= '0;
            r_ioctl_dout <= '0;
            r_hold_cnt   <= '0;
            r_tail_cnt   <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == DONE) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (r_state == IDLE && dl_start) begin
                r_remaining <= dl_length;
                r_addr      <= '0;
                r_is_cart   <= dl_is_cart;
            end

            if (r_state == WR_LO || r_state == WR_HI) begin
                r_hold_cnt <= '0;
            end else if ((r_state == HOLD_LO || r_state == HOLD_HI) && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            r_tail_cnt <= (r_state == TAIL) ? r_tail_cnt + 1'b1 : '0;

            if (w_load_lo) begin
                r_word       <= w_head;
                r_ioctl_addr <= r_addr;
                r_ioctl_dout <= w_lo_dout;
            end

            if (w_advance) begin
                r_addr      <= r_addr + 25'd2;
                r_remaining <= w_rem_after;
            end

            if (w_load_hi) begin
                r_ioctl_addr <= r_addr + 25'd2;
                r_ioctl_dout <= w_hi_dout;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_download_streamer.sv
// Directed bench for ioctl_download_streamer: a receiver model that stalls
// after each write, plus one task per scenario with hand-computed writes.
module tb_ioctl_download_streamer;

    localparam int FIFO_DEPTH   = 4;
    localparam int WAIT_LATENCY = 2;
    localparam int TAIL_CYCLES  = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_start = 1'b0;
    logic        dl_is_cart = 1'b0;
    logic [24:0] dl_length = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        dl_busy;
    logic        dl_done;
    logic        ioctl_download;
    logic        cart_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait = 1'b0;

    int checks = 0;
    int errors = 0;

    int wait_cycles = 0;
    bit force_stall = 1'b0;
    int rcv_cnt = 0;
    int done_cnt = 0;
    int dl_high_cnt = 0;
    int cart_high_cnt = 0;
    logic [24:0] wr_addr_q[$];
    logic [15:0] wr_dout_q[$];

    ioctl_download_streamer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WAIT_LATENCY(WAIT_LATENCY),
        .TAIL_CYCLES (TAIL_CYCLES)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .dl_start      (dl_start),
        .dl_is_cart    (dl_is_cart),
        .dl_length     (dl_length),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .dl_busy       (dl_busy),
        .dl_done       (dl_done),
        .ioctl_download(ioctl_download),
        .cart_download (cart_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait)
    );

    always #5 clk_sys = ~clk_sys;

    // Receiver model and monitor, evaluated just after each rising edge.
    always @(posedge clk_sys) begin
        #1;
        if (ioctl_wr === 1'b1) begin
            checks++;
            if (ioctl_wait !== 1'b0) begin
                errors++;
                $display("FAIL wr_while_wait addr=%0h wait=%b required 0", ioctl_addr, ioctl_wait);
            end
            $display("write addr=%0h dout=%04h", ioctl_addr, ioctl_dout);
            wr_addr_q.push_back(ioctl_addr);
            wr_dout_q.push_back(ioctl_dout);
            rcv_cnt = wait_cycles;
        end else if (rcv_cnt > 0) begin
            rcv_cnt--;
        end
        ioctl_wait = force_stall || (rcv_cnt > 0);
        if (dl_done === 1'b1)        done_cnt++;
        if (ioctl_download === 1'b1) dl_high_cnt++;
        if (cart_download === 1'b1)  cart_high_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon;
        done_cnt = 0;
        dl_high_cnt = 0;
        cart_high_cnt = 0;
        wr_addr_q.delete();
        wr_dout_q.delete();
    endtask

    task automatic start_xfer(input logic [24:0] len, input logic cart);
        dl_length  = len;
        dl_is_cart = cart;
        dl_start   = 1'b1;
        @(negedge clk_sys);
        dl_start   = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        bit ok;
        bit rdy;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 500; t++) begin
            rdy = in_ready;
            @(posedge clk_sys);
            @(negedge clk_sys);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout word=%08h accepted=0 required 1", d);
        end
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (dl_done === 1'b1) begin
                seen = 1'b1;
                if (poke) begin
                    dl_start   = 1'b1;
                    dl_length  = 25'd4;
                    dl_is_cart = 1'b1;
                end
                break;
            end
            @(negedge clk_sys);
        end
        if (seen) begin
            @(negedge clk_sys);
            dl_start = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout seen=0 required 1");
        end
    endtask

    task automatic reset_dut;
        reset_n = 1'b0;
        dl_start = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic test_reset;
        reset_dut();
        checks += 8;
        if (ioctl_download !== 1'b0) begin errors++; $display("FAIL rst_download got=%b required 0", ioctl_download); end
        if (cart_download !== 1'b0)  begin errors++; $display("FAIL rst_cart got=%b required 0", cart_download); end
        if (dl_busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%b required 0", dl_busy); end
        if (dl_done !== 1'b0)        begin errors++; $display("FAIL rst_done got=%b required 0", dl_done); end
        if (ioctl_wr !== 1'b0)       begin errors++; $display("FAIL rst_wr got=%b required 0", ioctl_wr); end
        if (in_ready !== 1'b0)       begin errors++; $display("FAIL rst_ready got=%b required 0", in_ready); end
        if (ioctl_addr !== 25'd0)    begin errors++; $display("FAIL rst_addr got=%0h required 0", ioctl_addr); end
        if (ioctl_dout !== 16'd0)    begin errors++; $display("FAIL rst_dout got=%04h required 0", ioctl_dout); end
    endtask

    task automatic test_basic;
        logic [24:0] ea[4] = '{25'd0, 25'd2, 25'd4, 25'd6};
        logic [15:0] ed[4] = '{16'hC300, 16'h0150, 16'h2211, 16'h4433};
        wait_cycles = 3;
        clear_mon();
        start_xfer(25'd8, 1'b1);
        checks += 4;
        if (ioctl_download !== 1'b1) begin errors++; $display("FAIL basic_download got=%b required 1", ioctl_download); end
        if (cart_download !== 1'b1)  begin errors++; $display("FAIL basic_cart got=%b required 1", cart_download); end
        if (dl_busy !== 1'b1)        begin errors++; $display("FAIL basic_busy got=%b required 1", dl_busy); end
        if (in_ready !== 1'b1)       begin errors++; $display("FAIL basic_ready got=%b required 1", in_ready); end
        push_word(32'h00C3_5001);
        push_word(32'h1122_3344);
        wait_done(400, 1'b0);
        checks += 3;
        if (ioctl_download !== 1'b0) begin errors++; $display("FAIL basic_download_end got=%b required 0", ioctl_download); end
        if (done_cnt !== 1)          begin errors++; $display("FAIL basic_done_count got=%0d required 1", done_cnt); end
        if (wr_addr_q.size() !== 4)  begin errors++; $display("FAIL basic_wr_count got=%0d required 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks += 2;
            if (wr_addr_q[i] !== ea[i]) begin errors++; $display("FAIL basic_addr[%0d] got=%0h required %0h", i, wr_addr_q[i], ea[i]); end
            if (wr_dout_q[i] !== ed[i]) begin errors++; $display("FAIL basic_dout[%0d] got=%04h required %04h", i, wr_dout_q[i], ed[i]); end
        end
    endtask

    task automatic test_odd_length;
        logic [24:0] ea[3] = '{25'd0, 25'd2, 25'd4};
        logic [15:0] ed[3] = '{16'hBBAA, 16'hDDCC, 16'h00EE};
        wait_cycles = 1;
        clear_mon();
        start_xfer(25'd5, 1'b1);
        push_word(32'hAABB_CCDD);
        push_word(32'hEEFF_0011);
        push_word(32'h1234_5678);
        wait_done(400, 1'b0);
        checks += 2;
        if (done_cnt !== 1)         begin errors++; $display("FAIL odd_done_count got=%0d required 1", done_cnt); end
        if (wr_addr_q.size() !== 3) begin errors++; $display("FAIL odd_wr_count got=%0d required 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks += 2;
            if (wr_addr_q[i] !== ea[i]) begin errors++; $display("FAIL odd_addr[%0d] got=%0h required %0h", i, wr_addr_q[i], ea[i]); end
            if (wr_dout_q[i] !== ed[i]) begin errors++; $display("FAIL odd_dout[%0d] got=%04h required %04h", i, wr_dout_q[i], ed[i]); end
        end
    endtask

    task automatic test_zero_length;
        wait_cycles = 0;
        clear_mon();
        start_xfer(25'd0, 1'b1);
        wait_done(100, 1'b0);
        checks += 4;
        if (dl_high_cnt !== TAIL_CYCLES + 1)   begin errors++; $display("FAIL zero_download_cycles got=%0d required %0d", dl_high_cnt, TAIL_CYCLES + 1); end
        if (cart_high_cnt !== TAIL_CYCLES + 1) begin errors++; $display("FAIL zero_cart_cycles got=%0d required %0d", cart_high_cnt, TAIL_CYCLES + 1); end
        if (wr_addr_q.size() !== 0)            begin errors++; $display("FAIL zero_wr_count got=%0d required 0", wr_addr_q.size()); end
        if (done_cnt !== 1)                    begin errors++; $display("FAIL zero_done_count got=%0d required 1", done_cnt); end
    endtask

    task automatic test_backpressure;
        logic [31:0] words[8];
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_dout;
        int idx;
        int cyc;
        bit rdy;
        // Byte at address a holds a+1, so the halfword at a is {a+2, a+1}.
        for (int i = 0; i < 8; i++) begin
            words[i] = {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
        end
        wait_cycles = 0;
        clear_mon();
        force_stall = 1'b1;
        @(negedge clk_sys);
        start_xfer(25'd32, 1'b1);
        idx = 0;
        cyc = 0;
        in_valid = 1'b1;
        while (idx < 8 && cyc < 1000) begin
            in_data = words[idx];
            rdy = in_ready;
            if (cyc == 60) begin
                checks += 3;
                if (idx !== FIFO_DEPTH)      begin errors++; $display("FAIL bp_accepted got=%0d required %0d", idx, FIFO_DEPTH); end
                if (in_ready !== 1'b0)       begin errors++; $display("FAIL bp_ready_full got=%b required 0", in_ready); end
                if (wr_addr_q.size() !== 0)  begin errors++; $display("FAIL bp_wr_during_stall got=%0d required 0", wr_addr_q.size()); end
            end
            if (cyc == 100) force_stall = 1'b0;
            @(posedge clk_sys);
            if (rdy) idx++;
            @(negedge clk_sys);
            cyc++;
        end
        in_valid = 1'b0;
        force_stall = 1'b0;
        checks++;
        if (idx !== 8) begin errors++; $display("FAIL bp_all_accepted got=%0d required 8", idx); end
        wait_done(2000, 1'b0);
        checks++;
        if (wr_addr_q.size() !== 16) begin errors++; $display("FAIL bp_wr_count got=%0d required 16", wr_addr_q.size()); end
        for (int k = 0; k < 16 && k < wr_addr_q.size(); k++) begin
            b0 = 8'(2*k+1);
            b1 = 8'(2*k+2);
            exp_dout = {b1, b0};
            checks += 2;
            if (wr_addr_q[k] !== 25'(2*k)) begin errors++; $display("FAIL bp_addr[%0d] got=%0h required %0h", k, wr_addr_q[k], 2*k); end
            if (wr_dout_q[k] !== exp_dout) begin errors++; $display("FAIL bp_dout[%0d] got=%04h required %04h", k, wr_dout_q[k], exp_dout); end
        end
    endtask

    task automatic test_cart_off;
        int restarted;
        wait_cycles = 2;
        clear_mon();
        start_xfer(25'd4, 1'b0);
        push_word(32'hDEAD_BEEF);
        // A start pulse mid-transfer must be ignored, including its cart flag.
        dl_length  = 25'd2;
        dl_is_cart = 1'b1;
        dl_start   = 1'b1;
        @(negedge clk_sys);
        dl_start   = 1'b0;
        // A start pulse in the DONE cycle must also be ignored.
        wait_done(400, 1'b1);
        restarted = 0;
        for (int t = 0; t < 6; t++) begin
            if (ioctl_download !== 1'b0 || dl_busy !== 1'b0) restarted++;
            @(negedge clk_sys);
        end
        checks += 6;
        if (restarted !== 0)                 begin errors++; $display("FAIL cart_start_in_done got=%0d busy cycles required 0", restarted); end
        if (cart_high_cnt !== 0)             begin errors++; $display("FAIL cart_off_cycles got=%0d required 0", cart_high_cnt); end
        if (dl_high_cnt < TAIL_CYCLES + 1)   begin errors++; $display("FAIL cart_download_cycles got=%0d required >=%0d", dl_high_cnt, TAIL_CYCLES + 1); end
        if (done_cnt !== 1)                  begin errors++; $display("FAIL cart_done_count got=%0d required 1", done_cnt); end
        if (wr_addr_q.size() !== 2)          begin errors++; $display("FAIL cart_wr_count got=%0d required 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2 && (wr_dout_q[0] !== 16'hADDE || wr_dout_q[1] !== 16'hEFBE || wr_addr_q[1] !== 25'd2)) begin
            errors++;
            $display("FAIL cart_writes got=%04h,%04h@%0h required ADDE,EFBE@2", wr_dout_q[0], wr_dout_q[1], wr_addr_q[1]);
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        wait_cycles = 4;
        clear_mon();
        start_xfer(25'd8, 1'b1);
        push_word(32'h0102_0304);
        push_word(32'h0506_0708);
        hit = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (ioctl_wr === 1'b1 && ioctl_addr === 25'd2) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rmid_reach_hi got=0 required 1"); end
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        checks += 8;
        if (ioctl_download !== 1'b0) begin errors++; $display("FAIL rmid_download got=%b required 0", ioctl_download); end
        if (cart_download !== 1'b0)  begin errors++; $display("FAIL rmid_cart got=%b required 0", cart_download); end
        if (dl_busy !== 1'b0)        begin errors++; $display("FAIL rmid_busy got=%b required 0", dl_busy); end
        if (dl_done !== 1'b0)        begin errors++; $display("FAIL rmid_done got=%b required 0", dl_done); end
        if (ioctl_wr !== 1'b0)       begin errors++; $display("FAIL rmid_wr got=%b required 0", ioctl_wr); end
        if (in_ready !== 1'b0)       begin errors++; $display("FAIL rmid_ready got=%b required 0", in_ready); end
        if (ioctl_addr !== 25'd0)    begin errors++; $display("FAIL rmid_addr got=%0h required 0", ioctl_addr); end
        if (ioctl_dout !== 16'd0)    begin errors++; $display("FAIL rmid_dout got=%04h required 0", ioctl_dout); end
        reset_n = 1'b1;
        repeat (40) @(negedge clk_sys);
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d required 0", done_cnt); end

        wait_cycles = 0;
        clear_mon();
        start_xfer(25'd4, 1'b1);
        push_word(32'hCAFE_F00D);
        wait_done(400, 1'b0);
        checks++;
        if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL rnew_wr_count got=%0d required 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            checks += 4;
            if (wr_addr_q[0] !== 25'd0)     begin errors++; $display("FAIL rnew_addr0 got=%0h required 0", wr_addr_q[0]); end
            if (wr_dout_q[0] !== 16'hFECA)  begin errors++; $display("FAIL rnew_dout0 got=%04h required FECA", wr_dout_q[0]); end
            if (wr_addr_q[1] !== 25'd2)     begin errors++; $display("FAIL rnew_addr1 got=%0h required 2", wr_addr_q[1]); end
            if (wr_dout_q[1] !== 16'h0DF0)  begin errors++; $display("FAIL rnew_dout1 got=%04h required 0DF0", wr_dout_q[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_length();
        test_zero_length();
        test_backpressure();
        test_cart_off();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
